tx_serial_ascii: RTL and testbench
==================================

# tx_serial_ascii

Asynchronous serial transmitter for 7-bit ASCII characters. It sits directly downstream of the serial-output control unit and datapath mux. It accepts a one-cycle `partida` pulse and the muxed character, shifts out a 10-bit frame on `saida_serial`, and returns a one-cycle `pronto` pulse. That pulse is the `serial_enviado` input of the control unit.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200 baud). Legal range is ≥ 2.
- `clock`, input, 1: system clock, rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `partida`, input, 1: start request. Sampled only in `repouso`.
- `dados_ascii`, input, 7: character to send. Sampled once per frame (see Operation).
- `saida_serial`, output, 1: serial line, idle high.
- `pronto`, output, 1: one-cycle pulse when the stop slot completes.
- `ocupado`, output, 1: high in `preparacao` and `transmissao`.
- `db_estado`, output, 2: state code. `repouso`=00, `preparacao`=01, `transmissao`=10, `final`=11.

## Operation
- Moore FSM with four states: `repouso`, `preparacao`, `transmissao`, `final`.
- `repouso`:
  - If `partida`=1, go to `preparacao`; otherwise stay.
- `preparacao` (exactly one cycle):
  - Load the 10-bit shift register with `{stop=1, bit9, dados_ascii[6:0], start=0}`.
  - Clear the bit counter and tick counter.
  - Go to `transmissao`.
  - Data is sampled one cycle after `partida`, because the upstream mux select settles the cycle after the start pulse.
- `transmissao`:
  - `saida_serial` = shift_reg[0].
  - The tick counter runs 0..`CLKS_PER_BIT`-1. On the terminal tick, shift right (fill with 1) and increment the 4-bit bit counter.
  - After the 10th terminal tick, go to `final`.
- `final` (one cycle):
  - `pronto`=1, `saida_serial`=1.
  - Go to `repouso`.
- Frame order on the line: start, data LSB first (d0..d6), bit9, stop.
- `partida` outside `repouso` is ignored and is not queued.
- Reset values:
  - State `repouso`.
  - `saida_serial`=1, `pronto`=0, `ocupado`=0, `db_estado`=00.
  - Shift register all ones; counters 0.
- Reset mid-frame: the line returns high asynchronously. No `pronto` is emitted, and the frame is abandoned.
- Illegal state encodings are unreachable; the default next state is `repouso`.
- Tick counter width is $clog2(`CLKS_PER_BIT`). The counter must not wrap inside a bit period.

## Timing
- `partida` sampled high at edge E0. The FSM is in `preparacao` after E0 and in `transmissao` after E1.
- `saida_serial`=0 from E1 to E1+N, where N=`CLKS_PER_BIT`.
- Bit k occupies edges E1+kN to E1+(k+1)N, for k=0..9.
- `final` spans E1+10N to E1+10N+1, with `pronto` high for that single cycle.
- Latency from `partida` edge to `pronto` rising is 10N+1 cycles. The next `partida` is accepted at edge E1+10N+1 at the earliest.
- All outputs are registered or decoded from state only, with no combinational path from inputs.

## Configuration
- Macro: `TX_SERIAL_PARITY_EN`.
- Defined: bit9 is the odd parity bit, equal to ~^`dados_ascii` (ones count of data plus parity is odd). The frame is 7O1.
- Undefined: bit9 is constant 1, acting as a second stop bit. The frame is 7N2.
- Frame length and all timing are identical in both configurations.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless stated.
1. Reset: assert `reset` for 3 cycles, then release. Required: `saida_serial`=1, `pronto`=0, `ocupado`=0, `db_estado`=00, and all hold with `partida`=0.
2. Send 0x35 ('5') with parity enabled. Required: line sequence 0,1,0,1,0,1,1,0,1,1, each bit exactly 4 cycles; `pronto` pulse 41 cycles after the `partida` edge, high for 1 cycle.
3. Apply `dados_ascii`=0x31 in the `partida` cycle and 0x32 in the next cycle. Required: 0x32 is transmitted, giving data bits 0,1,0,0,1,1,0 and parity 0.
4. Pulse `partida` at bit 3 and again during `final`. Required: both are ignored, a single frame is sent, and exactly one `pronto`.
5. Assert `reset` during bit 5. Required: `saida_serial`=1 immediately; `pronto` never rises; a new `partida` after reset produces a full correct frame.
6. Parity disabled, send 0x23 ('#'). Required: bit9=1 (it would be 0 with parity), stop=1, total 41 cycles.

Source files
------------

// File: rtl/tx_serial_ascii.sv
// Serial transmitter for 7-bit ASCII characters, 10-bit frame, LSB first.
// Define TX_SERIAL_PARITY_EN for a 7O1 frame; the default build sends 7N2.
module tx_serial_ascii #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       ocupado,
  output logic [1:0] db_estado
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    REPOUSO     = 2'b00,
    PREPARACAO  = 2'b01,
    TRANSMISSAO = 2'b10,
    FINAL       = 2'b11
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_tick;
  logic          w_tick_fim;
  logic          w_ultimo_bit;
  logic          w_bit9;

`ifdef TX_SERIAL_PARITY_EN
  assign w_bit9 = ~^dados_ascii;
`else
  assign w_bit9 = 1'b1;
`endif

  assign w_tick_fim   = (r_tick == TICK_MAX);
  assign w_ultimo_bit = (r_bit_cnt == 4'd9);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= REPOUSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox       = r_estado;
    saida_serial = 1'b1;
    pronto       = 1'b0;
    ocupado      = 1'b0;
    db_estado    = r_estado;
    case (r_estado)
      REPOUSO: begin
        if (partida) w_prox = PREPARACAO;
      end
      PREPARACAO: begin
        ocupado = 1'b1;
        w_prox  = TRANSMISSAO;
      end
      TRANSMISSAO: begin
        ocupado      = 1'b1;
        saida_serial = r_shift[0];
        if (w_tick_fim && w_ultimo_bit) w_prox = FINAL;
      end
      FINAL: begin
        pronto = 1'b1;
        w_prox = REPOUSO;
      end
      default: w_prox = REPOUSO;
    endcase
  end

  // Data is captured in preparacao: the upstream mux settles one cycle late.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_tick    <= '0;
    end else begin
      case (r_estado)
        PREPARACAO: begin
          r_shift   <= {1'b1, w_bit9, dados_ascii, 1'b0};
          r_bit_cnt <= '0;
          r_tick    <= '0;
        end
        TRANSMISSAO: begin
          if (w_tick_fim) begin
            r_tick    <= '0;
            r_shift   <= {1'b1, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        FINAL: begin
          r_bit_cnt <= '0;
          r_tick    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serial_ascii.sv
// Bench for tx_serial_ascii: per-cycle frame model derived from bit timing.
// Honours TX_SERIAL_PARITY_EN the same way as the design build.
module tb_tx_serial_ascii;

  localparam int N  = 4;
  localparam int FR = 10 * N;

  logic       clock = 1'b0;
  logic       reset;
  logic       partida;
  logic [6:0] dados_ascii;
  logic       saida_serial;
  logic       pronto;
  logic       ocupado;
  logic [1:0] db_estado;

  int n_checks = 0;
  int n_fails  = 0;

  tx_serial_ascii #(.CLKS_PER_BIT(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .dados_ascii (dados_ascii),
    .saida_serial(saida_serial),
    .pronto      (pronto),
    .ocupado     (ocupado),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic bit9_of(logic [6:0] d);
`ifdef TX_SERIAL_PARITY_EN
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  // k = number of rising edges since the edge that sampled partida
  function automatic logic exp_line(int k, logic [6:0] d);
    int idx;
    if (k < 1 || k > FR) return 1'b1;
    idx = (k - 1) / N;
    if (idx == 0) return 1'b0;
    if (idx <= 7) return d[idx-1];
    if (idx == 8) return bit9_of(d);
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_db(int k);
    if (k == 0) return 2'b01;
    if (k <= FR) return 2'b10;
    if (k == FR + 1) return 2'b11;
    return 2'b00;
  endfunction

  task automatic run_frame(input logic [6:0] d_a, input logic [6:0] d_b,
                           input int pk1, input int pk2, input int tail,
                           input string nm);
    int n_pr;
    int lat;
    n_pr = 0;
    lat  = -1;
    dados_ascii = d_a;
    partida     = 1'b1;
    for (int k = 0; k <= FR + 2 + tail; k++) begin
      @(negedge clock);
      partida     = 1'b0;
      dados_ascii = (k == 0) ? d_b : 7'($urandom);
      n_checks += 4;
      if (saida_serial !== exp_line(k, d_b)) begin
        n_fails++;
        $display("FAIL %s line k=%0d got %b want %b",
                 nm, k, saida_serial, exp_line(k, d_b));
      end
      if (db_estado !== exp_db(k)) begin
        n_fails++;
        $display("FAIL %s db_estado k=%0d got %b want %b",
                 nm, k, db_estado, exp_db(k));
      end
      if (ocupado !== (k <= FR)) begin
        n_fails++;
        $display("FAIL %s ocupado k=%0d got %b want %b",
                 nm, k, ocupado, (k <= FR));
      end
      if (pronto !== (k == FR + 1)) begin
        n_fails++;
        $display("FAIL %s pronto k=%0d got %b want %b",
                 nm, k, pronto, (k == FR + 1));
      end
      if (pronto === 1'b1) begin
        n_pr++;
        if (lat < 0) lat = k;
      end
      if (k == pk1 || k == pk2) partida = 1'b1;
    end
    partida = 1'b0;
    n_checks += 2;
    if (n_pr !== 1) begin
      n_fails++;
      $display("FAIL %s pronto_count got %0d want 1", nm, n_pr);
    end
    if (lat !== FR + 1) begin
      n_fails++;
      $display("FAIL %s latency got %0d want %0d", nm, lat, FR + 1);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    partida     = 1'b0;
    dados_ascii = 7'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 2) reset = 1'b0;
      n_checks += 4;
      if (saida_serial !== 1'b1) begin
        n_fails++;
        $display("FAIL reset line c=%0d got %b want 1", i, saida_serial);
      end
      if (pronto !== 1'b0) begin
        n_fails++;
        $display("FAIL reset pronto c=%0d got %b want 0", i, pronto);
      end
      if (ocupado !== 1'b0) begin
        n_fails++;
        $display("FAIL reset ocupado c=%0d got %b want 0", i, ocupado);
      end
      if (db_estado !== 2'b00) begin
        n_fails++;
        $display("FAIL reset db_estado c=%0d got %b want 00", i, db_estado);
      end
    end
  endtask

  task automatic test_char_5();
    run_frame(7'h35, 7'h35, -1, -1, 2, "char_35");
  endtask

  task automatic test_char_hash();
    run_frame(7'h23, 7'h23, -1, -1, 2, "char_23");
  endtask

  task automatic test_late_data();
    run_frame(7'h31, 7'h32, -1, -1, 2, "late_data");
  endtask

  task automatic test_ignored_partida();
    run_frame(7'h4d, 7'h4d, 3 * N + 1, FR + 1, 3 * N, "ignored_partida");
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0] d;
    d = 7'($urandom);
    dados_ascii = d;
    partida     = 1'b1;
    @(negedge clock);
    partida = 1'b0;
    repeat (5 * N + 2) @(negedge clock);
    n_checks++;
    if (db_estado !== 2'b10) begin
      n_fails++;
      $display("FAIL abort pre_state got %b want 10", db_estado);
    end
    #1 reset = 1'b1;
    #1;
    n_checks += 3;
    if (saida_serial !== 1'b1) begin
      n_fails++;
      $display("FAIL abort line got %b want 1", saida_serial);
    end
    if (ocupado !== 1'b0 || db_estado !== 2'b00) begin
      n_fails++;
      $display("FAIL abort state got %b/%b want 0/00", ocupado, db_estado);
    end
    if (pronto !== 1'b0) begin
      n_fails++;
      $display("FAIL abort pronto got %b want 0", pronto);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clock);
      n_checks += 2;
      if (pronto !== 1'b0) begin
        n_fails++;
        $display("FAIL abort pronto_after c=%0d got %b want 0", i, pronto);
      end
      if (saida_serial !== 1'b1) begin
        n_fails++;
        $display("FAIL abort line_after c=%0d got %b want 1", i, saida_serial);
      end
    end
    run_frame(d, d, -1, -1, 1, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      logic [6:0] d;
      d = 7'($urandom);
      run_frame(d, d, -1, -1, 0, "back_to_back");
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [6:0] da;
      logic [6:0] db;
      int p1;
      int p2;
      da = 7'($urandom);
      db = 7'($urandom);
      p1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FR + 1)) : -1;
      p2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FR + 1)) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_frame(da, db, p1, p2, int'($urandom_range(0, N)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_char_5();
    test_char_hash();
    test_late_data();
    test_ignored_partida();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
